// File: rtl/lif_ring_network.sv
// Ring of leaky integrate-and-fire neurons; neuron i is excited by neuron (i-1) mod N
// through a DELAY-stage synaptic shift register. Neuron 0 also takes an external stimulus.
module lif_ring_network #(
    parameter int N_NEURONS = 4,
    parameter int W         = 8,
    parameter int DELAY     = 2,
    parameter int REFRAC    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 stim,
    input  logic [W-1:0]         weight,
    input  logic [W-1:0]         threshold,
    input  logic [W-1:0]         leak,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 spike_output,
    output logic [15:0]          spike_count
);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [RW-1:0] REFRAC_LOAD = RW'(REFRAC);
    localparam logic [W+1:0]  V_MAX       = {2'b00, {W{1'b1}}};

    logic [N_NEURONS-1:0] fire;
    logic [15:0]          count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            localparam int SRC = (gi == 0) ? N_NEURONS - 1 : gi - 1;

            logic [W-1:0]     v_reg;
            logic [RW-1:0]    refr_reg;
            logic             spike_reg;
            logic [DELAY-1:0] dly_reg;
            logic             syn_in;
            logic             stim_in;
            logic             fire_n;
            logic [W+1:0]     leaked;
            logic [W+1:0]     sum;
            logic [W-1:0]     v_next;

            assign syn_in  = dly_reg[DELAY-1];
            assign stim_in = (gi == 0) ? stim : 1'b0;

            // Leak clamps at zero before the excitatory inputs are added; the sum
            // has two guard bits so two full weights can never wrap.
            always_comb begin
                leaked = (v_reg > leak) ? {2'b00, v_reg - leak} : '0;
                sum    = leaked
                       + (syn_in  ? {2'b00, weight} : '0)
                       + (stim_in ? {2'b00, weight} : '0);
                v_next = (sum > V_MAX) ? {W{1'b1}} : sum[W-1:0];
                fire_n = (refr_reg == '0) && (threshold != '0) && (v_next >= threshold);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_reg     <= '0;
                    refr_reg  <= '0;
                    spike_reg <= 1'b0;
                    dly_reg   <= '0;
                end else if (enable) begin
                    // The synapse keeps shifting while the target is refractory,
                    // so pulses landing in that window are dropped.
                    dly_reg[0] <= spikes[SRC];
                    for (int k = 1; k < DELAY; k++) begin
                        dly_reg[k] <= dly_reg[k-1];
                    end
                    if (refr_reg != '0) begin
                        refr_reg  <= refr_reg - RW'(1);
                        v_reg     <= '0;
                        spike_reg <= 1'b0;
                    end else if (fire_n) begin
                        refr_reg  <= REFRAC_LOAD;
                        v_reg     <= '0;
                        spike_reg <= 1'b1;
                    end else begin
                        v_reg     <= v_next;
                        spike_reg <= 1'b0;
                    end
                end else begin
                    spike_reg <= 1'b0;
                end
            end

            assign spikes[gi] = spike_reg;
            assign fire[gi]   = fire_n;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (enable && fire[0] && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign spike_count  = count_reg;
    assign spike_output = spikes[0];
endmodule

// File: tb/tb_lif_ring_network.sv
// Bench for lif_ring_network: directed scenarios plus randomized traffic against a
// behavioural model that tracks each neuron's potential and spike history in plain arithmetic.
module tb_lif_ring_network;
    localparam int N      = 4;
    localparam int W      = 8;
    localparam int DELAY  = 2;
    localparam int REFRAC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, enable, stim;
    logic [W-1:0] weight, threshold, leak;
    logic [N-1:0] spikes;
    logic         spike_output;
    logic [15:0]  spike_count;

    logic         reset2, enable2, stim2;
    logic [W-1:0] weight2, threshold2, leak2;
    logic [N-1:0] spikes2;
    logic         spike_output2;
    logic [15:0]  spike_count2;

    int checks = 0;
    int errors = 0;

    lif_ring_network #(.N_NEURONS(N), .W(W), .DELAY(DELAY), .REFRAC(REFRAC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .stim(stim),
        .weight(weight), .threshold(threshold), .leak(leak),
        .spikes(spikes), .spike_output(spike_output), .spike_count(spike_count)
    );

    // Zero refractory period lets neuron 0 fire every cycle, so the counter can be
    // driven to saturation within a reasonable run.
    lif_ring_network #(.N_NEURONS(N), .W(W), .DELAY(DELAY), .REFRAC(0)) dut_fast (
        .clk(clk), .reset(reset2), .enable(enable2), .stim(stim2),
        .weight(weight2), .threshold(threshold2), .leak(leak2),
        .spikes(spikes2), .spike_output(spike_output2), .spike_count(spike_count2)
    );

    // Behavioural model: potentials, refractory time left, visible spikes, and a queue
    // of past spike vectors from which each synapse reads DELAY enabled cycles later.
    int           m_v[N];
    int           m_refr[N];
    bit [N-1:0]   m_spk;
    int           m_count;
    bit [N-1:0]   m_hist[$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i]    = 0;
            m_refr[i] = 0;
        end
        m_spk   = '0;
        m_count = 0;
        m_hist.delete();
        for (int d = 0; d < DELAY; d++) m_hist.push_back('0);
    endtask

    task automatic model_edge();
        bit [N-1:0] syn;
        bit [N-1:0] nspk;
        int         t;
        if (reset) begin
            model_reset();
            return;
        end
        if (!enable) begin
            m_spk = '0;
            return;
        end
        m_hist.push_back(m_spk);
        syn  = m_hist.pop_front();
        nspk = '0;
        for (int i = 0; i < N; i++) begin
            int src = (i + N - 1) % N;
            if (m_refr[i] > 0) begin
                m_refr[i] = m_refr[i] - 1;
                m_v[i]    = 0;
            end else begin
                t = m_v[i] - int'(leak);
                if (t < 0) t = 0;
                if (syn[src]) t = t + int'(weight);
                if (i == 0 && stim) t = t + int'(weight);
                if (t > (1 << W) - 1) t = (1 << W) - 1;
                if (threshold != 0 && t >= int'(threshold)) begin
                    nspk[i]   = 1'b1;
                    m_v[i]    = 0;
                    m_refr[i] = REFRAC;
                    if (i == 0 && m_count < 65535) m_count = m_count + 1;
                end else begin
                    m_v[i] = t;
                end
            end
        end
        m_spk = nspk;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; stim = 1'b0;
        step();
        step();
        checks++;
        if (spikes !== '0 || spike_output !== 1'b0 || spike_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: spikes=%b out=%b count=%0d, expected 0/0/0",
                     spikes, spike_output, spike_count);
        end
        reset = 1'b0;
        step();
        checks++;
        if (spikes !== '0) begin
            errors++;
            $display("FAIL reset_first_edge: spikes=%b expected 0000", spikes);
        end
        $display("test_reset: done");
    endtask

    task automatic test_ring();
        logic [N-1:0] exp_spk;
        weight = 8'd10; threshold = 8'd10; leak = 8'd0; stim = 1'b0;
        do_reset();
        stim = 1'b1;
        for (int e = 1; e <= 121; e++) begin
            step();
            stim = 1'b0;
            exp_spk = ((e - 1) % 3 == 0) ? (N'(1) << (((e - 1) / 3) % N)) : '0;
            checks++;
            if (spikes !== exp_spk || spikes !== m_spk || spike_output !== exp_spk[0]) begin
                errors++;
                $display("FAIL ring_edge%0d: spikes=%b out=%b, expected %b", e, spikes, spike_output, exp_spk);
            end
        end
        checks++;
        if (spike_count !== 16'd11) begin
            errors++;
            $display("FAIL ring_count: spike_count=%0d expected 11", spike_count);
        end
        step();
        step();
        do_reset();
        checks++;
        if (spikes !== '0 || spike_count !== 16'd0) begin
            errors++;
            $display("FAIL ring_midreset: spikes=%b count=%0d expected 0/0", spikes, spike_count);
        end
        step();
        checks++;
        if (spikes !== '0) begin
            errors++;
            $display("FAIL ring_after_reset: spikes=%b expected 0000", spikes);
        end
        $display("test_ring: 10 laps then reset mid-oscillation");
    endtask

    task automatic test_leak();
        weight = 8'd4; threshold = 8'd10; leak = 8'd1; stim = 1'b0;
        do_reset();
        stim = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (spikes[0] !== (e == 3)) begin
                errors++;
                $display("FAIL leak1_edge%0d: spikes0=%b expected %b", e, spikes[0], (e == 3));
            end
        end
        stim = 1'b0;
        leak = 8'd5;
        do_reset();
        stim = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if (spikes !== '0 || spikes !== m_spk) begin
                errors++;
                $display("FAIL leak5_edge%0d: spikes=%b expected 0000", e, spikes);
            end
        end
        stim = 1'b0;
        $display("test_leak: leak=1 fires on third edge, leak=5 stays silent");
    endtask

    task automatic test_refractory();
        weight = 8'd10; threshold = 8'd10; leak = 8'd0; stim = 1'b0;
        do_reset();
        stim = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            checks++;
            if (spikes[0] !== (e % 4 == 1) || spikes !== m_spk) begin
                errors++;
                $display("FAIL refrac_edge%0d: spikes=%b expected spike0=%b", e, spikes, (e % 4 == 1));
            end
        end
        checks++;
        if (spike_count !== 16'd3) begin
            errors++;
            $display("FAIL refrac_count: spike_count=%0d expected 3", spike_count);
        end
        stim = 1'b0;
        weight = 8'd200; threshold = 8'd255;
        do_reset();
        stim = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            step();
            checks++;
            if (spikes[0] !== (e == 2)) begin
                errors++;
                $display("FAIL saturate_edge%0d: spikes0=%b expected %b", e, spikes[0], (e == 2));
            end
        end
        stim = 1'b0;
        $display("test_refractory: period 4 under held stim, saturation fires");
    endtask

    task automatic test_enable_freeze();
        logic [N-1:0] exp_spk;
        int           en_e;
        weight = 8'd10; threshold = 8'd10; leak = 8'd0; stim = 1'b0;
        do_reset();
        stim = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            enable = !(e >= 6 && e <= 10);
            step();
            stim = 1'b0;
            en_e = (e <= 5) ? e : e - 5;
            if (!enable) exp_spk = '0;
            else exp_spk = ((en_e - 1) % 3 == 0) ? (N'(1) << (((en_e - 1) / 3) % N)) : '0;
            checks++;
            if (spikes !== exp_spk || spikes !== m_spk) begin
                errors++;
                $display("FAIL freeze_edge%0d: spikes=%b expected %b", e, spikes, exp_spk);
            end
            if (e >= 2 && e <= 17) begin
                checks++;
                if (spike_count !== 16'd1) begin
                    errors++;
                    $display("FAIL freeze_count_edge%0d: spike_count=%0d expected 1", e, spike_count);
                end
            end
        end
        enable = 1'b1;
        threshold = 8'd0;
        do_reset();
        stim = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            checks++;
            if (spikes !== '0) begin
                errors++;
                $display("FAIL thresh0_edge%0d: spikes=%b expected 0000", e, spikes);
            end
        end
        stim = 1'b0;
        $display("test_enable_freeze: 5-cycle freeze shifts schedule, threshold 0 silent");
    endtask

    task automatic test_random();
        reset = 1'b0; enable = 1'b1; stim = 1'b0;
        do_reset();
        for (int blk = 0; blk < 24; blk++) begin
            weight    = 8'($urandom_range(1, 128));
            threshold = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 160));
            leak      = 8'($urandom_range(0, 15));
            for (int e = 0; e < 25; e++) begin
                stim   = ($urandom_range(0, 99) < 30);
                enable = ($urandom_range(0, 99) < 92);
                reset  = ($urandom_range(0, 99) < 2);
                step();
                checks++;
                if (spikes !== m_spk || spike_output !== m_spk[0] || spike_count !== 16'(m_count)) begin
                    errors++;
                    $display("FAIL random_blk%0d_e%0d: spikes=%b out=%b count=%0d, expected %b/%b/%0d",
                             blk, e, spikes, spike_output, spike_count, m_spk, m_spk[0], m_count);
                end
            end
            $display("test_random: block %0d w=%0d thr=%0d leak=%0d count=%0d",
                     blk, weight, threshold, leak, spike_count);
        end
        reset = 1'b0; enable = 1'b1; stim = 1'b0;
    endtask

    task automatic test_counter_saturation();
        weight2 = 8'd10; threshold2 = 8'd10; leak2 = 8'd0; enable2 = 1'b1; stim2 = 1'b0;
        reset2 = 1'b1;
        step();
        step();
        reset2 = 1'b0;
        stim2  = 1'b1;
        step();
        checks++;
        if (spike_count2 !== 16'd1 || spikes2[0] !== 1'b1) begin
            errors++;
            $display("FAIL count_first: count=%0d spike0=%b expected 1/1", spike_count2, spikes2[0]);
        end
        for (int e = 2; e <= 65534; e++) step();
        checks++;
        if (spike_count2 !== 16'hFFFE) begin
            errors++;
            $display("FAIL count_preload: count=%h expected fffe", spike_count2);
        end
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if (spike_count2 !== 16'hFFFF || spikes2[0] !== 1'b1) begin
                errors++;
                $display("FAIL count_sat_%0d: count=%h spike0=%b expected ffff/1", e, spike_count2, spikes2[0]);
            end
        end
        stim2 = 1'b0;
        $display("test_counter_saturation: count held at %h", spike_count2);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; stim = 1'b0;
        weight = '0; threshold = '0; leak = '0;
        reset2 = 1'b1; enable2 = 1'b1; stim2 = 1'b0;
        weight2 = '0; threshold2 = '0; leak2 = '0;
        model_reset();
        test_reset();
        test_ring();
        test_leak();
        test_refractory();
        test_enable_freeze();
        test_random();
        test_counter_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
